// File: rtl/force_writeback_router_half_shell_if.sv
// Bundle of the PE-side partial-force ports and the force-cache write ports.
// The master side drives partial forces and cache readiness; the slave side is the router.
interface force_writeback_router_half_shell_if #(
  parameter int unsigned NUM_CELLS = 27,
  parameter int unsigned PID_W     = 8,
  parameter int unsigned FORCE_W   = 96
);
  logic [13:0]          pe_valid    [NUM_CELLS];
  logic [PID_W-1:0]     pe_pid      [NUM_CELLS][14];
  logic [FORCE_W-1:0]   pe_force    [NUM_CELLS][14];
  logic [13:0]          pe_ready    [NUM_CELLS];
  logic [NUM_CELLS-1:0] fc_wr_valid;
  logic [PID_W-1:0]     fc_wr_pid   [NUM_CELLS];
  logic [FORCE_W-1:0]   fc_wr_force [NUM_CELLS];
  logic [NUM_CELLS-1:0] fc_wr_ready;

  modport master (
    output pe_valid, pe_pid, pe_force, fc_wr_ready,
    input  pe_ready, fc_wr_valid, fc_wr_pid, fc_wr_force
  );

  modport slave (
    input  pe_valid, pe_pid, pe_force, fc_wr_ready,
    output pe_ready, fc_wr_valid, fc_wr_pid, fc_wr_force
  );
endinterface

// File: rtl/force_writeback_router_half_shell.sv
// Half-shell force write-back router: one hold register per (source cell, slot),
// a 14-input round-robin arbiter and output register per destination force cache.
module force_writeback_router_half_shell #(
  parameter int unsigned X_DIM   = 3,
  parameter int unsigned Y_DIM   = 3,
  parameter int unsigned Z_DIM   = 3,
  parameter int unsigned PID_W   = 8,
  parameter int unsigned FORCE_W = 96
) (
  input  logic clk,
  input  logic rst_n,
  force_writeback_router_half_shell_if.slave bus,
  output logic idle
);
  localparam int unsigned NUM_CELLS = X_DIM * Y_DIM * Z_DIM;
  localparam int unsigned NUM_SLOTS = 14;

  // Half-shell slot offset along one axis (0=x, 1=y, 2=z).
  function automatic int slot_off(int unsigned n, int unsigned axis);
    int ox, oy, oz;
    case (n)
      0:       begin ox =  0; oy =  0; oz = 0; end
      1:       begin ox =  1; oy =  0; oz = 0; end
      2:       begin ox = -1; oy =  1; oz = 0; end
      3:       begin ox =  0; oy =  1; oz = 0; end
      4:       begin ox =  1; oy =  1; oz = 0; end
      5:       begin ox = -1; oy = -1; oz = 1; end
      6:       begin ox =  0; oy = -1; oz = 1; end
      7:       begin ox =  1; oy = -1; oz = 1; end
      8:       begin ox = -1; oy =  0; oz = 1; end
      9:       begin ox =  0; oy =  0; oz = 1; end
      10:      begin ox =  1; oy =  0; oz = 1; end
      11:      begin ox = -1; oy =  1; oz = 1; end
      12:      begin ox =  0; oy =  1; oz = 1; end
      default: begin ox =  1; oy =  1; oz = 1; end
    endcase
    return (axis == 0) ? ox : ((axis == 1) ? oy : oz);
  endfunction

  // Cell reached from c by +/- the slot offset, wrapping each axis independently.
  function automatic int unsigned shift_cell(int unsigned c, int unsigned n, int sgn);
    int x, y, z;
    x = int'(c % X_DIM) + sgn * slot_off(n, 0);
    y = int'((c / X_DIM) % Y_DIM) + sgn * slot_off(n, 1);
    z = int'(c / (X_DIM * Y_DIM)) + sgn * slot_off(n, 2);
    x = (x + int'(X_DIM)) % int'(X_DIM);
    y = (y + int'(Y_DIM)) % int'(Y_DIM);
    z = (z + int'(Z_DIM)) % int'(Z_DIM);
    return $unsigned(z * int'(X_DIM * Y_DIM) + y * int'(X_DIM) + x);
  endfunction

  logic [NUM_SLOTS-1:0] hold_valid_q [NUM_CELLS];
  logic [PID_W-1:0]     hold_pid_q   [NUM_CELLS][NUM_SLOTS];
  logic [FORCE_W-1:0]   hold_force_q [NUM_CELLS][NUM_SLOTS];

  logic                 pend     [NUM_CELLS][NUM_SLOTS];
  logic [PID_W-1:0]     in_pid   [NUM_CELLS][NUM_SLOTS];
  logic [FORCE_W-1:0]   in_force [NUM_CELLS][NUM_SLOTS];
  logic                 clr      [NUM_CELLS][NUM_SLOTS];

  logic [NUM_CELLS-1:0] load_en;
  logic [NUM_CELLS-1:0] gnt_any;
  logic [3:0]           gnt_idx  [NUM_CELLS];

  logic [NUM_CELLS-1:0] out_valid_q;
  logic [PID_W-1:0]     out_pid_q   [NUM_CELLS];
  logic [FORCE_W-1:0]   out_force_q [NUM_CELLS];
  logic [3:0]           rr_q        [NUM_CELLS];

  // Destination view: input n of cell d is the hold register of source d - offset_n.
  for (genvar d = 0; d < NUM_CELLS; d++) begin : g_dst
    for (genvar n = 0; n < NUM_SLOTS; n++) begin : g_in
      localparam int unsigned Src = shift_cell(d, n, -1);
      assign pend[d][n]     = hold_valid_q[Src][n];
      assign in_pid[d][n]   = hold_pid_q[Src][n];
      assign in_force[d][n] = hold_force_q[Src][n];
    end
  end

  // Source view: a hold is freed when its destination grants its slot index.
  for (genvar s = 0; s < NUM_CELLS; s++) begin : g_src
    for (genvar n = 0; n < NUM_SLOTS; n++) begin : g_slot
      localparam int unsigned Dst = shift_cell(s, n, 1);
      assign clr[s][n] = load_en[Dst] && gnt_any[Dst] && (gnt_idx[Dst] == 4'(n));
    end
  end

  // Round-robin search from rr over the 14 inputs of each destination.
  always_comb begin
    for (int unsigned d = 0; d < NUM_CELLS; d++) begin
      load_en[d] = !out_valid_q[d] || bus.fc_wr_ready[d];
      gnt_any[d] = 1'b0;
      gnt_idx[d] = '0;
      for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
        int unsigned idx;
        idx = (32'(rr_q[d]) + k) % NUM_SLOTS;
        if (!gnt_any[d] && pend[d][idx]) begin
          gnt_any[d] = 1'b1;
          gnt_idx[d] = 4'(idx);
        end
      end
    end
  end

  // Hold registers: capture on accept, free on grant (both never hit the same slot).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned s = 0; s < NUM_CELLS; s++) begin
        hold_valid_q[s] <= '0;
        for (int unsigned n = 0; n < NUM_SLOTS; n++) begin
          hold_pid_q[s][n]   <= '0;
          hold_force_q[s][n] <= '0;
        end
      end
    end else begin
      for (int unsigned s = 0; s < NUM_CELLS; s++) begin
        for (int unsigned n = 0; n < NUM_SLOTS; n++) begin
          if (clr[s][n]) begin
            hold_valid_q[s][n] <= 1'b0;
          end else if (bus.pe_valid[s][n] && !hold_valid_q[s][n]) begin
            hold_valid_q[s][n] <= 1'b1;
            hold_pid_q[s][n]   <= bus.pe_pid[s][n];
            hold_force_q[s][n] <= bus.pe_force[s][n];
          end
        end
      end
    end
  end

  // Output registers and pointers: reload whenever the slot is empty or draining.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= '0;
      for (int unsigned d = 0; d < NUM_CELLS; d++) begin
        out_pid_q[d]   <= '0;
        out_force_q[d] <= '0;
        rr_q[d]        <= '0;
      end
    end else begin
      for (int unsigned d = 0; d < NUM_CELLS; d++) begin
        if (load_en[d]) begin
          out_valid_q[d] <= gnt_any[d];
          if (gnt_any[d]) begin
            out_pid_q[d]   <= in_pid[d][gnt_idx[d]];
            out_force_q[d] <= in_force[d][gnt_idx[d]];
            rr_q[d]        <= (gnt_idx[d] == 4'd13) ? 4'd0 : gnt_idx[d] + 4'd1;
          end
        end
      end
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    idle = !(|out_valid_q);
    for (int unsigned s = 0; s < NUM_CELLS; s++) begin
      bus.pe_ready[s] = ~hold_valid_q[s];
      if (|hold_valid_q[s]) idle = 1'b0;
    end
    bus.fc_wr_valid = out_valid_q;
    for (int unsigned d = 0; d < NUM_CELLS; d++) begin
      bus.fc_wr_pid[d]   = out_pid_q[d];
      bus.fc_wr_force[d] = out_force_q[d];
    end
  end
endmodule

// File: tb/tb_force_writeback_router_half_shell.sv
// Bench for the half-shell write-back router on a 3x3x3 grid: a transaction-level
// model checked every cycle, plus directed scenarios with literal expectations.
module tb_force_writeback_router_half_shell;
  localparam int XD = 3, YD = 3, ZD = 3, NC = 27, NS = 14, PW = 8, FW = 96;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic idle;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  force_writeback_router_half_shell_if #(.NUM_CELLS(NC), .PID_W(PW), .FORCE_W(FW)) bus ();

  force_writeback_router_half_shell #(
    .X_DIM(XD), .Y_DIM(YD), .Z_DIM(ZD), .PID_W(PW), .FORCE_W(FW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .idle(idle)
  );

  int dxs [14] = '{0, 1, -1, 0, 1, -1, 0, 1, -1, 0, 1, -1, 0, 1};
  int dys [14] = '{0, 0, 1, 1, 1, -1, -1, -1, 0, 0, 0, 1, 1, 1};
  int dzs [14] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1};

  function automatic int dest_of(int s, int n);
    int x, y, z;
    x = (s % XD + dxs[n] + XD) % XD;
    y = ((s / XD) % YD + dys[n] + YD) % YD;
    z = (s / (XD * YD) + dzs[n] + ZD) % ZD;
    return z * XD * YD + y * XD + x;
  endfunction

  // Source cell feeding input n of the centre cell (1,1,1); no wrap needed there.
  function automatic int src13(int n);
    return (1 - dzs[n]) * 9 + (1 - dys[n]) * 3 + (1 - dxs[n]);
  endfunction

  function automatic logic [FW-1:0] mkf(int s, int n, logic [7:0] pid);
    return {8'hA5, 8'(s), 16'(n), 24'hC0DE00, pid, 32'(s * 100 + n)};
  endfunction

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Transaction-level model: pending forces, per-destination output and pointer.
  int          dtab     [NC][NS];
  bit          m_hold_v [NC][NS];
  logic [7:0]  m_hold_p [NC][NS];
  logic [FW-1:0] m_hold_f [NC][NS];
  bit          m_out_v  [NC];
  logic [7:0]  m_out_p  [NC];
  logic [FW-1:0] m_out_f [NC];
  int          m_rr     [NC];

  task automatic model_clear();
    for (int c = 0; c < NC; c++) begin
      m_out_v[c] = 0;
      m_rr[c] = 0;
      for (int n = 0; n < NS; n++) m_hold_v[c][n] = 0;
    end
  endtask

  task automatic model_step();
    bit old_v [NC][NS];
    old_v = m_hold_v;
    for (int d = 0; d < NC; d++) begin
      if (!m_out_v[d] || bus.fc_wr_ready[d]) begin
        bit found;
        found = 0;
        for (int k = 0; k < NS; k++) begin
          int n;
          n = (m_rr[d] + k) % NS;
          for (int s = 0; s < NC; s++) begin
            if (!found && old_v[s][n] && dtab[s][n] == d) begin
              found = 1;
              m_out_p[d] = m_hold_p[s][n];
              m_out_f[d] = m_hold_f[s][n];
              m_hold_v[s][n] = 0;
              m_rr[d] = (n + 1) % NS;
            end
          end
        end
        m_out_v[d] = found;
      end
    end
    for (int s = 0; s < NC; s++) begin
      for (int n = 0; n < NS; n++) begin
        if (bus.pe_valid[s][n] && !old_v[s][n]) begin
          m_hold_v[s][n] = 1;
          m_hold_p[s][n] = bus.pe_pid[s][n];
          m_hold_f[s][n] = bus.pe_force[s][n];
        end
      end
    end
  endtask

  initial begin
    for (int s = 0; s < NC; s++)
      for (int n = 0; n < NS; n++) dtab[s][n] = dest_of(s, n);
    model_clear();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_clear();
      else model_step();
    end
  end

  // Every-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        chk("rst_fc_wr_valid", bus.fc_wr_valid, 0);
        chk("rst_idle", idle, 1);
        chk("rst_pe_ready0", bus.pe_ready[0], 14'h3FFF);
      end else begin
        logic [NC-1:0] ev;
        bit any;
        any = 0;
        for (int s = 0; s < NC; s++) begin
          logic [13:0] er;
          for (int n = 0; n < NS; n++) begin
            er[n] = !m_hold_v[s][n];
            if (m_hold_v[s][n]) any = 1;
          end
          chk($sformatf("model_pe_ready[%0d]", s), bus.pe_ready[s], er);
        end
        for (int d = 0; d < NC; d++) begin
          ev[d] = m_out_v[d];
          if (m_out_v[d]) begin
            any = 1;
            chk($sformatf("model_pid[%0d]", d), bus.fc_wr_pid[d], m_out_p[d]);
            chk($sformatf("model_force[%0d]", d), bus.fc_wr_force[d], m_out_f[d]);
          end
        end
        chk("model_fc_wr_valid", bus.fc_wr_valid, ev);
        chk("model_idle", idle, !any);
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_pe(int s, int n, logic [7:0] pid);
    bus.pe_valid[s][n] = 1'b1;
    bus.pe_pid[s][n] = pid;
    bus.pe_force[s][n] = mkf(s, n, pid);
  endtask

  task automatic clr_pe();
    for (int s = 0; s < NC; s++) bus.pe_valid[s] = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    for (int s = 0; s < NC; s++) begin
      bus.pe_valid[s] = '0;
      for (int n = 0; n < NS; n++) begin
        bus.pe_pid[s][n] = '0;
        bus.pe_force[s][n] = '0;
      end
    end
    bus.fc_wr_ready = '1;
    repeat (3) step();
    #2;
    chk("reset_idle", idle, 1);
    chk("reset_valid", bus.fc_wr_valid, 0);
    chk("reset_ready", bus.pe_ready[0], 14'h3FFF);
    step();
    rst_n = 1'b1;

    // Single force, home slot of cell 0.
    step();
    set_pe(0, 0, 8'd5);
    step();
    clr_pe();
    #2;
    chk("t1_not_yet", bus.fc_wr_valid[0], 0);
    chk("t1_slot_busy", bus.pe_ready[0][0], 0);
    step();
    #2;
    chk("t1_valid", bus.fc_wr_valid, 27'h1);
    chk("t1_pid", bus.fc_wr_pid[0], 8'd5);
    chk("t1_force", bus.fc_wr_force[0], mkf(0, 0, 8'd5));
    chk("t1_slot_free", bus.pe_ready[0][0], 1);
    step();
    #2;
    chk("t1_done", bus.fc_wr_valid[0], 0);
    chk("t1_idle", idle, 1);

    // Wrapping slots into cell 0; rr[0]=1 so slot 1 wins first.
    step();
    set_pe(26, 13, 8'h21);
    set_pe(2, 1, 8'h22);
    step();
    clr_pe();
    #2;
    chk("t2_busy", idle, 0);
    step();
    #2;
    chk("t2_only_cell0_a", bus.fc_wr_valid, 27'h1);
    chk("t2_first_pid", bus.fc_wr_pid[0], 8'h22);
    step();
    #2;
    chk("t2_only_cell0_b", bus.fc_wr_valid, 27'h1);
    chk("t2_second_pid", bus.fc_wr_pid[0], 8'h21);
    chk("t2_second_force", bus.fc_wr_force[0], mkf(26, 13, 8'h21));
    step();
    #2;
    chk("t2_done", bus.fc_wr_valid, 0);

    // Full 14-way burst into cell 13, twice.
    for (int b = 0; b < 2; b++) begin
      step();
      for (int n = 0; n < NS; n++) set_pe(src13(n), n, 8'(8'h40 + n + 16 * b));
      step();
      clr_pe();
      for (int k = 0; k < NS; k++) begin
        step();
        #2;
        chk($sformatf("t3_valid_b%0d_k%0d", b, k), bus.fc_wr_valid, 27'h1 << 13);
        chk($sformatf("t3_pid_b%0d_k%0d", b, k), bus.fc_wr_pid[13], 8'(8'h40 + k + 16 * b));
      end
      step();
      #2;
      chk($sformatf("t3_end_b%0d", b), bus.fc_wr_valid[13], 0);
    end

    // Backpressure on cell 0 with a second force waiting in slot 1 of cell 2.
    step();
    bus.fc_wr_ready[0] = 1'b0;
    set_pe(0, 0, 8'd7);
    set_pe(2, 1, 8'd8);
    step();
    clr_pe();
    step();
    #2;
    chk("t4_loaded", bus.fc_wr_valid[0], 1);
    chk("t4_pid", bus.fc_wr_pid[0], 8'd7);
    for (int i = 0; i < 5; i++) begin
      step();
      #2;
      chk($sformatf("t4_hold_valid%0d", i), bus.fc_wr_valid[0], 1);
      chk($sformatf("t4_hold_pid%0d", i), bus.fc_wr_pid[0], 8'd7);
      chk($sformatf("t4_hold_force%0d", i), bus.fc_wr_force[0], mkf(0, 0, 8'd7));
      chk($sformatf("t4_slot_held%0d", i), bus.pe_ready[2][1], 0);
    end
    step();
    bus.fc_wr_ready[0] = 1'b1;
    step();
    #2;
    chk("t4_next_pid", bus.fc_wr_pid[0], 8'd8);
    chk("t4_next_valid", bus.fc_wr_valid[0], 1);
    chk("t4_slot_freed", bus.pe_ready[2][1], 1);
    step();
    #2;
    chk("t4_done", bus.fc_wr_valid[0], 0);

    // Reset with ten forces in flight.
    step();
    bus.fc_wr_ready = '0;
    for (int c = 0; c < 5; c++) begin
      set_pe(c, 0, 8'(8'h60 + c));
      set_pe(c, 1, 8'(8'h70 + c));
    end
    step();
    clr_pe();
    step();
    #1;
    chk("t5_busy", idle, 0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_valid_cleared", bus.fc_wr_valid, 0);
    chk("t5_idle", idle, 1);
    for (int s = 0; s < NC; s++)
      chk($sformatf("t5_ready[%0d]", s), bus.pe_ready[s], 14'h3FFF);
    step();
    step();
    rst_n = 1'b1;
    bus.fc_wr_ready = '1;
    for (int i = 0; i < 10; i++) begin
      step();
      #2;
      chk($sformatf("t5_no_stale%0d", i), bus.fc_wr_valid, 0);
    end

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
